alu_pipe: RTL
=============

# alu_pipe

Parametrised, handshaked successor to the single-cycle registered ALU. It executes the eight base operations (add, sub, and, or, xor, sll, srl, sra) plus signed and unsigned set-less-than and an iterative multiply. Operands enter through a valid/ready input port and results leave through a registered valid/ready output port with status flags. The block sits between the register-file read stage and writeback, and absorbs writeback backpressure without dropping results.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of two
- MUL_EN, 1, 1 = MUL implemented; 0 = MUL opcode treated as illegal
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block accepts; transfer when in_valid & in_ready at a rising edge
- op  in  4  operation code (alu_op_t)
- in_1, in_2  in  WIDTH each  operands, signed two's complement
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer accepts result
- out  out  WIDTH  result
- zero, neg, carry, ovf, err  out  1 each  flags registered with out

## Operation
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA.
  - 1000 SLT (signed; result 1/0), 1001 SLTU (unsigned), 1010 MUL (low WIDTH bits of product).
  - 1011–1111 illegal.
- Shift amount is in_2[$clog2(WIDTH)-1:0]; upper bits are ignored.
- Flags:
  - zero = (out == 0); neg = out[WIDTH-1].
  - carry: ADD = carry-out of the WIDTH+1-bit sum; SUB = borrow (in_1 < in_2 unsigned); all other ops = 0.
  - ovf: signed overflow, ADD/SUB only; all other ops = 0.
  - err = 1 only for an illegal op (also MUL when MUL_EN=0). An illegal op produces out=0, all other flags 0, and still completes with latency 1.
- FSM states:
  - IDLE:
    - Single-cycle op accepted → result loaded into the output register at the accepting edge; stay in IDLE.
    - MUL accepted → go to MUL_RUN with cnt=0.
  - MUL_RUN: one shift-add step per cycle. After WIDTH steps, load out/flags, set out_valid, return to IDLE.
- in_ready = reset_n & (state==IDLE) & (!out_valid | out_ready). It is combinational; there is no combinational path from in_valid to in_ready.
- MUL result sign: take the low WIDTH bits of the unsigned product of the two's-complement bit patterns. These are correct for signed operands.

## Timing
- Reset (reset_n low, asynchronous):
  - state=IDLE, out_valid=0, out=0, all flags 0, cnt=0.
  - in_ready reads 0 while reset_n is low and 1 in the first cycle after release.
- Single-cycle op accepted at edge k: out/flags valid and out_valid=1 from edge k. Latency 1; throughput 1 per cycle when out_ready is held high.
- MUL accepted at edge k: in_ready=0 from edge k. Result and out_valid=1 appear at edge k+WIDTH (WIDTH cycles). in_ready returns high the same cycle if out_ready=1.
- Backpressure: while out_valid & !out_ready, out and flags are held bit-stable and in_ready=0.
- Simultaneous consume and accept (out_ready & in_valid & in_ready at one edge): the old result retires and the new single-cycle result replaces it at that same edge, so out_valid stays 1.
- A consume with no new accept clears out_valid at that edge.
- MUL in progress: out_ready only drains the previously held result. A MUL cannot start while an unconsumed result is held.
- reset_n low mid-MUL abandons the operation; no result is emitted after release.
- in_1, in_2 and op are sampled only at the accepting edge; changes during MUL_RUN have no effect.

## Structure
- Package alu_pkg:
  - alu_op_t (4-bit enum, encodings above).
  - WORD_SIZE = 32 default constant.
  - alu_flags_t struct {zero, neg, carry, ovf, err}.
- Sub-module alu_mul_iter (WIDTH):
  - Ports: start, a, b, busy, done, product.
  - Shift-add datapath with a $clog2(WIDTH)+1-bit counter.
  - Instantiated only when MUL_EN=1 (generate).
- Top level: combinational op mux, flag logic, the IDLE/MUL_RUN FSM, and the output register/handshake.

## Test plan
1. Reset, then ADD 9+11 → out=20, out_valid the edge after accept. SUB 11−9 → 2. SUB 9−11 → 0xFFFFFFFE, neg=1, carry=1.
2. ADD 0x7FFFFFFF+1 → 0x80000000, ovf=1, neg=1. ADD 0xFFFFFFFF+1 → 0, zero=1, carry=1, ovf=0.
3. in_1=30, in_2=5: SLL → 960, SRL → 0. SRA −64>>3 → −8. in_2=37 shifts by 5. SLT −1<1 → 1; SLTU 0xFFFFFFFF<1 → 0.
4. MUL 1234×5678 → 7006652 and −3×7 → 0xFFFFFFEB. Check in_ready=0 for exactly 32 cycles and out_valid at accept+32. Op 1100 → out=0, err=1.
5. out_ready=0 while issuing ADDs (1+1, 2+2, 3+3): the first result is held stable and in_ready=0. Raise out_ready → results 2, 4, 6 retire in order, one per cycle, with none lost or duplicated.
6. Pull reset_n low at MUL step 10 → out_valid=0 and out=0 immediately, no spurious result. A following ADD 9+11 → 20. Repeat scenarios 1–4 at WIDTH=8 and at MUL_EN=0 (MUL → err=1).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, flag bundle and default word size.
package alu_pkg;

  localparam int WORD_SIZE = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_MUL  = 4'b1010
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between the register-read stage, the ALU and writeback.
interface alu_pipe_if #(parameter int WIDTH = alu_pkg::WORD_SIZE);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, op, in_1, in_2, out_ready,
    input  in_ready, out_valid, out, zero, neg, carry, ovf, err
  );

  modport slave (
    input  in_valid, op, in_1, in_2, out_ready,
    output in_ready, out_valid, out, zero, neg, carry, ovf, err
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per operation.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  // The final step's sum is exposed combinationally so the caller can capture it on the last edge.
  assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign busy    = busy_q;
  assign product = acc_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (done) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops land in the output register at the accepting edge,
// MUL runs through the iterative multiplier; the output register absorbs writeback stalls.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = WORD_SIZE,
  parameter bit MUL_EN = 1'b1
) (
  input logic       clk,
  input logic       reset_n,
  alu_pipe_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  alu_flags_t       flags_q, flags_d;

  logic [WIDTH-1:0] alu_res;
  alu_flags_t       alu_flags;
  alu_flags_t       mul_flags;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [SHW-1:0]   shamt;
  logic             in_ready_w, accept, is_mul, mul_start;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_product;

  assign shamt    = bus.in_2[SHW-1:0];
  assign sum_ext  = {1'b0, bus.in_1} + {1'b0, bus.in_2};
  assign diff_ext = {1'b0, bus.in_1} - {1'b0, bus.in_2};

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (bus.op)
      OP_ADD: begin
        alu_res         = sum_ext[WIDTH-1:0];
        alu_flags.carry = sum_ext[WIDTH];
        alu_flags.ovf   = (bus.in_1[WIDTH-1] == bus.in_2[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != bus.in_1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res         = diff_ext[WIDTH-1:0];
        alu_flags.carry = diff_ext[WIDTH];
        alu_flags.ovf   = (bus.in_1[WIDTH-1] != bus.in_2[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != bus.in_1[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.in_1 & bus.in_2;
      OP_OR:   alu_res = bus.in_1 | bus.in_2;
      OP_XOR:  alu_res = bus.in_1 ^ bus.in_2;
      OP_SLL:  alu_res = bus.in_1 << shamt;
      OP_SRL:  alu_res = bus.in_1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.in_1) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.in_1) < $signed(bus.in_2)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.in_1 < bus.in_2};
      // MUL only reaches this mux when the multiplier is absent, so it is illegal here.
      default: alu_flags.err = 1'b1;
    endcase
    if (!alu_flags.err) begin
      alu_flags.zero = (alu_res == '0);
      alu_flags.neg  = alu_res[WIDTH-1];
    end
  end

  always_comb begin
    mul_flags      = '0;
    mul_flags.zero = (mul_product == '0);
    mul_flags.neg  = mul_product[WIDTH-1];
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (bus.in_1),
        .b       (bus.in_2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_busy    = 1'b0;
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  assign in_ready_w = reset_n && (state_q == IDLE) && !mul_busy &&
                      (!out_valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_w;
  assign is_mul     = MUL_EN && (bus.op == OP_MUL);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    flags_d     = flags_q;
    mul_start   = 1'b0;
    // A consume clears valid unless a new result is loaded below in the same cycle.
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = MUL_RUN;
          end else begin
            out_d       = alu_res;
            flags_d     = alu_flags;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL_RUN: begin
        if (mul_done) begin
          out_d       = mul_product;
          flags_d     = mul_flags;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.zero      = flags_q.zero;
  assign bus.neg       = flags_q.neg;
  assign bus.carry     = flags_q.carry;
  assign bus.ovf       = flags_q.ovf;
  assign bus.err       = flags_q.err;

endmodule
